cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmit end of the common data bus (CDB): collects completion results from N_SRC functional units and drives one broadcast per cycle to every CDB slave (register file unit, reservation stations).
- Arbitration is round-robin with a valid/grant handshake toward each source.
- The CDB output is registered.
- Tag 0 means "no producer" in the register file, so tag 0 is never broadcast.

Parameters:
- N_SRC, 4, number of requesting functional units (≥2).
- TAG_W, 4, width of the reservation-station tag carried on the CDB.
- ID_W, 64, width of the instruction identifier carried alongside each result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Low means reset asserted.
- flush  in  1  pipeline flush. Suppresses grants and kills the next broadcast.
- src_req  in  N_SRC  per-source request; bit i means source i has a result ready.
- src_tag  in  N_SRC*TAG_W  per-source tag; slice i is bits [i*TAG_W +: TAG_W].
- src_wdata  in  N_SRC*32  per-source result data.
- src_inst_id  in  N_SRC*ID_W  per-source instruction id.
- src_gnt  out  N_SRC  one-hot grant, combinational, same cycle as acceptance.
- cdb_wr  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_wdata  out  32  broadcast data.
- cdb_inst_id  out  ID_W  broadcast instruction id.
- err_tag0  out  1  sticky flag: a request carrying tag 0 was consumed.
- bcast_cnt  out  32  count of broadcasts issued.

Behaviour:
Reset
- While rst is low, asynchronously and at once: cdb_wr=0, cdb_tag=0, cdb_wdata=0, cdb_inst_id=0, err_tag0=0, bcast_cnt=0, rr_ptr=0.
- src_gnt is forced to all zeros while rst is low.
- Reset asserted mid-broadcast drops that broadcast. Sources re-request after reset.

Handshake
- A source raises req with a stable payload and holds both until it sees its gnt bit high at a rising edge. That edge completes the transfer.
- A source may drop req without a grant (for example on flush).
- Payload changes while req is high and ungranted are illegal.

Arbitration (combinational)
- Internal pointer rr_ptr, width clog2(N_SRC).
- Winner = first index with src_req set, searching circularly from rr_ptr upward, wrapping from N_SRC-1 to 0.
- src_gnt = onehot(winner) when any req is set and flush=0; otherwise all zeros.
- At most one grant per cycle.

Update on grant edge (cycle T)
- rr_ptr <= (winner+1) mod N_SRC.
- If the winner's tag ≠ 0:
  - cdb_wr <= 1.
  - cdb_tag, cdb_wdata, cdb_inst_id <= the winner's slices.
  - bcast_cnt <= bcast_cnt+1 (wraps at 2^32).
- If the winner's tag = 0:
  - cdb_wr <= 0; cdb_* data fields hold their previous values.
  - err_tag0 <= 1.
  - bcast_cnt unchanged.
- Latency: grant in cycle T gives cdb_wr high for exactly cycle T+1.
- No backpressure from CDB slaves.

No grant (no req, or flush=1)
- cdb_wr <= 0.
- cdb_tag, cdb_wdata, cdb_inst_id hold their values.
- rr_ptr holds.

Flush
- A flush asserted in cycle T blocks grants in T; cdb_wr is 0 in T+1.
- A broadcast already registered (visible in T) is not retracted.

Other rules
- err_tag0 clears only on reset.
- Back-to-back grants every cycle are allowed, giving one broadcast per cycle.
- With all sources requesting continuously, each source is granted once per N_SRC cycles (no starvation).

Test Plan:
1. Reset mid-operation: pull rst low asynchronously while cdb_wr=1 with tag 5 → cdb_wr, cdb_tag, bcast_cnt, err_tag0 go to 0 before the next clock edge, and src_gnt=0. After release, the first grant goes to source 0 when all sources request.
2. Single request: src_req=4'b0100, tag=5, wdata=32'hDEADBEEF, inst_id=7 → src_gnt=4'b0100 the same cycle. Next cycle: cdb_wr=1, cdb_tag=5, cdb_wdata=DEADBEEF, cdb_inst_id=7. The cycle after: cdb_wr=0, bcast_cnt=1.
3. Round-robin saturation: all four sources request continuously from reset (tags 1..4) → grants 0,1,2,3,0 on consecutive cycles. cdb_wr stays high from the second cycle onward, and cdb_tag sequence is 1,2,3,4,1.
4. Wrap-around: with rr_ptr=2, src_req=4'b1010 → source 3 granted, then source 1. rr_ptr ends at 2.
5. Tag 0: source 0 requests with tag 0 → gnt[0]=1, cdb_wr stays 0 the next cycle, err_tag0=1 and stays 1, bcast_cnt unchanged, rr_ptr=1.
6. Flush: src_req=4'b0011 with flush=1 for 2 cycles → src_gnt=0 and cdb_wr=0 throughout, rr_ptr unchanged. On the first cycle after flush drops, with requests still held, source rr_ptr (or the next requester after it) is granted.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter: round-robin selection among N_SRC result
// producers, one registered broadcast per cycle; tag 0 results are swallowed.
module cdb_arbiter #(
  parameter int N_SRC = 4,
  parameter int TAG_W = 4,
  parameter int ID_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC*TAG_W-1:0]   src_tag,
  input  logic [N_SRC*32-1:0]      src_wdata,
  input  logic [N_SRC*ID_W-1:0]    src_inst_id,
  output logic [N_SRC-1:0]         src_gnt,
  output logic                     cdb_wr,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_wdata,
  output logic [ID_W-1:0]          cdb_inst_id,
  output logic                     err_tag0,
  output logic [31:0]              bcast_cnt
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_wr_q, cdb_wr_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_wdata_q, cdb_wdata_d;
  logic [ID_W-1:0]  cdb_inst_id_q, cdb_inst_id_d;
  logic             err_tag0_q, err_tag0_d;
  logic [31:0]      bcast_cnt_q, bcast_cnt_d;

  logic [TAG_W-1:0] tag_arr   [N_SRC];
  logic [31:0]      wdata_arr [N_SRC];
  logic [ID_W-1:0]  id_arr    [N_SRC];
  logic [PTR_W:0]   cand_sum  [N_SRC];
  logic [PTR_W-1:0] cand_idx  [N_SRC];

  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  logic             grant_en;
  logic [TAG_W-1:0] win_tag;

  // Candidate k is the source k positions after the pointer, wrapped into range.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign tag_arr[gi]   = src_tag[gi*TAG_W +: TAG_W];
    assign wdata_arr[gi] = src_wdata[gi*32 +: 32];
    assign id_arr[gi]    = src_inst_id[gi*ID_W +: ID_W];
    assign cand_sum[gi]  = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
    assign cand_idx[gi]  = (cand_sum[gi] >= (PTR_W+1)'(N_SRC))
                         ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(N_SRC))
                         : PTR_W'(cand_sum[gi]);
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_req[cand_idx[k]]) begin
        found  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end

  // Grants are gated by reset so no source sees a handshake while held in reset.
  assign grant_en = found & ~flush & rst;
  assign win_tag  = tag_arr[winner];
  assign ptr_next = (winner == PTR_W'(N_SRC-1)) ? '0 : winner + PTR_W'(1);

  always_comb begin
    src_gnt = '0;
    if (grant_en) begin
      src_gnt[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    cdb_wr_d      = 1'b0;
    cdb_tag_d     = cdb_tag_q;
    cdb_wdata_d   = cdb_wdata_q;
    cdb_inst_id_d = cdb_inst_id_q;
    err_tag0_d    = err_tag0_q;
    bcast_cnt_d   = bcast_cnt_q;
    if (grant_en) begin
      rr_ptr_d = ptr_next;
      if (win_tag != '0) begin
        cdb_wr_d      = 1'b1;
        cdb_tag_d     = win_tag;
        cdb_wdata_d   = wdata_arr[winner];
        cdb_inst_id_d = id_arr[winner];
        bcast_cnt_d   = bcast_cnt_q + 32'd1;
      end else begin
        // Tag 0 would alias "no producer" in the register file: consume, never broadcast.
        err_tag0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      cdb_wr_q      <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_wdata_q   <= '0;
      cdb_inst_id_q <= '0;
      err_tag0_q    <= 1'b0;
      bcast_cnt_q   <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_wr_q      <= cdb_wr_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_wdata_q   <= cdb_wdata_d;
      cdb_inst_id_q <= cdb_inst_id_d;
      err_tag0_q    <= err_tag0_d;
      bcast_cnt_q   <= bcast_cnt_d;
    end
  end

  assign cdb_wr      = cdb_wr_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_wdata   = cdb_wdata_q;
  assign cdb_inst_id = cdb_inst_id_q;
  assign err_tag0    = err_tag0_q;
  assign bcast_cnt   = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed grant vectors, expected broadcasts queued
// by the driver and popped/compared by a negedge monitor.
module tb_cdb_arbiter;

  localparam int N_SRC = 4;
  localparam int TAG_W = 4;
  localparam int ID_W  = 64;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [N_SRC-1:0]       src_req;
  logic [N_SRC*TAG_W-1:0] src_tag;
  logic [N_SRC*32-1:0]    src_wdata;
  logic [N_SRC*ID_W-1:0]  src_inst_id;
  logic [N_SRC-1:0]       src_gnt;
  logic                   cdb_wr;
  logic [TAG_W-1:0]       cdb_tag;
  logic [31:0]            cdb_wdata;
  logic [ID_W-1:0]        cdb_inst_id;
  logic                   err_tag0;
  logic [31:0]            bcast_cnt;

  cdb_arbiter #(.N_SRC(N_SRC), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_req(src_req), .src_tag(src_tag), .src_wdata(src_wdata), .src_inst_id(src_inst_id),
    .src_gnt(src_gnt), .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .cdb_inst_id(cdb_inst_id), .err_tag0(err_tag0), .bcast_cnt(bcast_cnt)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [ID_W-1:0]  id;
  } bc_t;

  bc_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mon_cnt = 0;

  logic [TAG_W-1:0] tag_a  [N_SRC];
  logic [31:0]      data_a [N_SRC];
  logic [ID_W-1:0]  id_a   [N_SRC];

  always_comb begin
    src_tag     = '0;
    src_wdata   = '0;
    src_inst_id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_tag[i*TAG_W +: TAG_W]   = tag_a[i];
      src_wdata[i*32 +: 32]       = data_a[i];
      src_inst_id[i*ID_W +: ID_W] = id_a[i];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [31:0] d,
                         input logic [ID_W-1:0] id);
    tag_a[i]  = t;
    data_a[i] = d;
    id_a[i]   = id;
  endtask

  // One cycle: drive at negedge, check the combinational grant, queue the broadcast it implies.
  task automatic cyc(input logic [N_SRC-1:0] req, input logic fl, input logic [N_SRC-1:0] exp_gnt);
    bc_t e;
    @(negedge clk);
    src_req = req;
    flush   = fl;
    #1;
    check("src_gnt", 64'(src_gnt), 64'(exp_gnt));
    for (int i = 0; i < N_SRC; i++) begin
      if (exp_gnt[i] && tag_a[i] != '0) begin
        e.tag  = tag_a[i];
        e.data = data_a[i];
        e.id   = id_a[i];
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    bc_t e;
    if (!rst) begin
      mon_cnt = 0;
    end else begin
      check("cdb_wr", 64'(cdb_wr), 64'(exp_q.size() != 0));
      if (cdb_wr && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mon_cnt++;
        check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
        check("cdb_wdata", 64'(cdb_wdata), 64'(e.data));
        check("cdb_inst_id", cdb_inst_id, e.id);
        check("bcast_cnt", 64'(bcast_cnt), 64'(mon_cnt));
        $display("bcast tag=%0h data=%08h id=%0h cnt=%0d", cdb_tag, cdb_wdata, cdb_inst_id, bcast_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    src_req = '0;
    for (int i = 0; i < N_SRC; i++) set_src(i, '0, '0, '0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // Single request from source 2
    set_src(2, 4'd5, 32'hDEADBEEF, 64'd7);
    cyc(4'b0100, 1'b0, 4'b0100);
    cyc(4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    #1;
    check("idle_cdb_wr", 64'(cdb_wr), 64'd0);
    check("idle_bcast_cnt", 64'(bcast_cnt), 64'd1);

    // Async reset while a tag-5 broadcast is on the bus
    cyc(4'b0100, 1'b0, 4'b0100);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_cdb_wr", 64'(cdb_wr), 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_wdata", 64'(cdb_wdata), 64'd0);
    check("rst_bcast_cnt", 64'(bcast_cnt), 64'd0);
    check("rst_err_tag0", 64'(err_tag0), 64'd0);
    check("rst_src_gnt", 64'(src_gnt), 64'd0);
    src_req = '0;
    @(negedge clk);
    #1 rst = 1'b1;

    // Round-robin saturation from reset, tags 1..4
    for (int i = 0; i < N_SRC; i++) set_src(i, TAG_W'(i+1), 32'hA000_0000 + i, 64'(100+i));
    cyc(4'b1111, 1'b0, 4'b0001);
    cyc(4'b1111, 1'b0, 4'b0010);
    cyc(4'b1111, 1'b0, 4'b0100);
    cyc(4'b1111, 1'b0, 4'b1000);
    cyc(4'b1111, 1'b0, 4'b0001);

    // Wrap-around: move pointer to 2, then 3 wins, then 1
    cyc(4'b0010, 1'b0, 4'b0010);
    cyc(4'b1010, 1'b0, 4'b1000);
    cyc(4'b1010, 1'b0, 4'b0010);

    // Flush two cycles; the broadcast already registered still shows
    cyc(4'b0011, 1'b1, 4'b0000);
    cyc(4'b0011, 1'b1, 4'b0000);
    cyc(4'b0011, 1'b0, 4'b0001);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Tag 0 from source 0: consumed, flagged, not broadcast
    set_src(0, 4'd0, 32'h0000_1234, 64'd99);
    cyc(4'b0001, 1'b0, 4'b0001);
    cyc(4'b0000, 1'b0, 4'b0000);
    check("tag0_err", 64'(err_tag0), 64'd1);
    check("tag0_bcast_cnt", 64'(bcast_cnt), 64'd9);
    cyc(4'b1111, 1'b0, 4'b0010);
    cyc(4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 1'b0, 4'b0000);
    check("sticky_err", 64'(err_tag0), 64'd1);
    check("final_bcast_cnt", 64'(bcast_cnt), 64'd10);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
